// File: rtl/alu_exec_unit.sv
// EX-stage ALU for the multicycle MIPS datapath: one-cycle ALU ops plus
// iterative MULT/DIV into HI/LO, with a start/busy/done handshake.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state_reg, state_next;
  logic [SHW-1:0]     count_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic               neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0]   result_reg, hi_reg, lo_reg;
  logic               zero_reg, ovf_reg, illegal_reg, done_reg;

  logic [WIDTH-1:0] sum, diff, op_result;
  logic             add_ovf, sub_ovf, op_ovf, op_illegal;
  logic             is_mul, is_div, is_signed;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    op_result  = '0;
    op_ovf     = 1'b0;
    op_illegal = 1'b0;
    is_mul     = 1'b0;
    is_div     = 1'b0;
    is_signed  = 1'b0;
    case (alu_op)
      2'b00: begin op_result = sum;  op_ovf = add_ovf; end
      2'b01: begin op_result = diff; op_ovf = sub_ovf; end
      2'b10: begin
        case (funct)
          6'b100000: begin op_result = sum;  op_ovf = add_ovf; end
          6'b100001: op_result = sum;
          6'b100010: begin op_result = diff; op_ovf = sub_ovf; end
          6'b100011: op_result = diff;
          6'b100100: op_result = a & b;
          6'b100101: op_result = a | b;
          6'b100110: op_result = a ^ b;
          6'b100111: op_result = ~(a | b);
          6'b101010: op_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
          6'b101011: op_result = {{(WIDTH-1){1'b0}}, a < b};
          6'b000000: op_result = b << shamt;
          6'b000010: op_result = b >> shamt;
          6'b000011: op_result = WIDTH'($signed(b) >>> shamt);
          6'b010000: op_result = hi_reg;
          6'b010010: op_result = lo_reg;
          6'b011000: begin is_mul = 1'b1; is_signed = 1'b1; end
          6'b011001: is_mul = 1'b1;
          6'b011010: begin is_div = 1'b1; is_signed = 1'b1; end
          6'b011011: is_div = 1'b1;
          default:   op_illegal = 1'b1;
        endcase
      end
      default: op_illegal = 1'b1;
    endcase
  end

  // Operand conditioning: the iteration is unsigned on magnitudes. A zero
  // divisor keeps the raw dividend so the remainder comes out equal to a.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg  = is_signed & a[WIDTH-1];
  assign b_neg  = is_signed & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, step_next, prod_fin;
  logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;
  logic               last_step, accept;

  assign mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};
  assign step_next = (state_reg == MUL) ? mul_next : div_next;

  assign prod_fin = neg_q_reg ? -step_next : step_next;
  assign quo      = step_next[WIDTH-1:0];
  assign rem      = step_next[2*WIDTH-1:WIDTH];
  assign fin_lo   = (state_reg == MUL) ? prod_fin[WIDTH-1:0] : (neg_q_reg ? -quo : quo);
  assign fin_hi   = (state_reg == MUL) ? prod_fin[2*WIDTH-1:WIDTH] : (neg_r_reg ? -rem : rem);

  assign last_step = (count_reg == SHW'(WIDTH-1));
  assign accept    = start && (state_reg == IDLE || state_reg == FIN);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, FIN: begin
        state_next = IDLE;
        if (start && is_mul)      state_next = MUL;
        else if (start && is_div) state_next = DIV;
      end
      MUL, DIV: if (last_step) state_next = FIN;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      result_reg  <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      zero_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      illegal_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        if (is_mul || is_div) begin
          count_reg <= '0;
          acc_reg   <= {{WIDTH{1'b0}}, (is_div && b_zero) ? a : a_mag};
          opnd_reg  <= b_mag;
          neg_q_reg <= (a_neg ^ b_neg) & ~(is_div & b_zero);
          neg_r_reg <= a_neg & is_div & ~b_zero;
        end else begin
          result_reg  <= op_result;
          zero_reg    <= (op_result == '0);
          ovf_reg     <= op_ovf;
          illegal_reg <= op_illegal;
          done_reg    <= 1'b1;
        end
      end else if (state_reg == MUL || state_reg == DIV) begin
        acc_reg   <= step_next;
        count_reg <= count_reg + SHW'(1);
        if (last_step) begin
          hi_reg      <= fin_hi;
          lo_reg      <= fin_lo;
          result_reg  <= fin_lo;
          zero_reg    <= (fin_lo == '0);
          ovf_reg     <= 1'b0;
          illegal_reg <= 1'b0;
          done_reg    <= 1'b1;
        end
      end
    end
  end

  assign busy    = (state_reg == MUL) || (state_reg == DIV);
  assign done    = done_reg;
  assign result  = result_reg;
  assign zero    = zero_reg;
  assign ovf     = ovf_reg;
  assign illegal = illegal_reg;
  assign hi      = hi_reg;
  assign lo      = lo_reg;

endmodule

// File: doc/alu_exec_unit.md
Name:
alu_exec_unit

Overview:
Parametrised successor to the combinational ALU-control decoder. Merges opcode/funct decode with a registered execution datapath. Adds shifts, unsigned compares, overflow detection, and iterative multi-cycle MULT/DIV with HI/LO registers. Sits in the EX stage of the multicycle MIPS datapath. Uses a start/busy/done handshake, so the controller stalls during long operations.

Parameters:
WIDTH, 32, datapath width in bits (>= 8, power of two)
SHW, $clog2(WIDTH), localparam, shift-amount width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  sample operands/op this cycle (honoured only when busy=0)
alu_op  input  2  00 add (LW/SW), 01 sub (BEQ), 10 R-type (use funct), 11 illegal
funct  input  6  R-type function code
shamt  input  SHW  shift amount for SLL/SRL/SRA
a  input  WIDTH  operand rs
b  input  WIDTH  operand rt
busy  output  1  multi-cycle operation in progress
done  output  1  one-cycle pulse: result/hi/lo/flags valid
result  output  WIDTH  registered result
zero  output  1  registered (result == 0)
ovf  output  1  signed overflow of ADD/SUB (flag only, no trap)
illegal  output  1  unsupported alu_op/funct on last completed op
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counter 0. Reset mid-operation aborts it: no done, hi/lo cleared.
- FSM states:
  - IDLE: accepts start.
  - MUL, DIV: iterate for WIDTH cycles.
  - FIN: one cycle; registers the final result.
- Single-cycle ops: start in cycle 0 -> result, zero, ovf, illegal and done=1 in cycle 1. busy stays 0.
- alu_op 00 -> a+b; alu_op 01 -> a-b; both update ovf.
- funct decode (alu_op=10):
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 101010 SLT (signed), 101011 SLTU.
  - 000000 SLL, 000010 SRL, 000011 SRA: operate on b by shamt.
  - 010000 MFHI, 010010 MFLO.
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
- ovf: set only by ADD/SUB and alu_op 00/01 on signed overflow; 0 for all other ops. ADDU/SUBU never set ovf. result is always the wrapped sum/difference.
- Illegal (unknown funct, or alu_op=11): done pulses in cycle 1 with illegal=1, result=0, hi/lo unchanged.
- Multi-cycle ops:
  - Start in cycle 0 latches magnitudes of a and b (absolute value for signed ops) and records the result sign.
  - busy=1 in cycles 1..WIDTH, one shift-add (MUL) or restoring-subtract (DIV) step per cycle.
  - Cycle WIDTH+1: sign fixup applied; hi/lo written; result=lo; zero=(lo==0); done=1; busy=0.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
- DIV/DIVU: lo = quotient (truncated toward zero), hi = remainder (sign of dividend).
- Divide by zero (signed or unsigned): lo = all ones, hi = a; no sign fixup; no error flag.
- Signed most-negative / -1: lo = most-negative, hi = 0.
- start while busy=1: ignored, no side effects.
- start in the done cycle (cycle WIDTH+1, busy=0): accepted.
- MFHI/MFLO read the hi/lo values present in the start cycle.
- result, zero, ovf, illegal hold their values between done pulses.

Test Plan:
1. Reset asserted 2 cycles mid-stream -> busy, done, result, hi, lo, ovf, illegal all 0.
2. Single-cycle ALU ops (WIDTH=32):
   - ADD a=7 b=5 -> cycle 1: result=12, done=1, zero=0.
   - alu_op=01, a=b=5 -> zero=1.
   - SLT a=FFFFFFFF b=1 -> result=1; SLTU same operands -> result=0.
3. Overflow and shift:
   - ADD a=7FFFFFFF b=1 -> result=80000000, ovf=1.
   - ADDU same operands -> ovf=0.
   - SRA b=80000000 shamt=4 -> result=F8000000.
4. MULT a=FFFFFFFD(-3) b=7:
   - busy=1 cycles 1..32.
   - Cycle 33: done=1, hi=FFFFFFFF, lo=FFFFFFEB.
   - Following MFHI -> FFFFFFFF.
   - start pulsed at cycle 5 -> ignored.
5. Division:
   - DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
   - DIVU a=1234 b=0 -> lo=FFFFFFFF, hi=1234.
   - DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0.
6. Abort and illegal:
   - MULTU with reset at cycle 10 -> no done, hi=lo=0, busy=0 next cycle.
   - funct=111111 -> done, illegal=1, result=0.
